// File: rtl/riscv_lsu.sv
// Load/store unit between a single-cycle RISC-V core and a word-wide data memory.
// Converts sized byte-address requests into aligned word transactions and extends load data.
module riscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        misaligned_o,
  output logic        bus_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      data_q;
  logic [2:0]       size_q;
  logic [1:0]       off_q;
  logic             req_c, legal_c, start_c, timeout_c;
  logic [3:0]       be_c;
  logic [31:0]      wd_c;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;

  // Reset also masks the request so stall/misaligned collapse immediately.
  assign req_c = core_req_i & rst_i;

  // Legality, byte enables and lane replication for the incoming request.
  always_comb begin
    legal_c = 1'b0;
    be_c    = 4'b0000;
    wd_c    = core_wd_i;
    case (core_size_i)
      SZ_B, SZ_BU: begin
        legal_c = !(core_we_i && (core_size_i == SZ_BU));
        be_c    = 4'b0001 << core_addr_i[1:0];
        wd_c    = {4{core_wd_i[7:0]}};
      end
      SZ_H, SZ_HU: begin
        legal_c = !core_addr_i[0] && !(core_we_i && (core_size_i == SZ_HU));
        be_c    = 4'b0011 << core_addr_i[1:0];
        wd_c    = {2{core_wd_i[15:0]}};
      end
      SZ_W: begin
        legal_c = (core_addr_i[1:0] == 2'b00);
        be_c    = 4'b1111;
      end
      default: ;
    endcase
  end

  assign start_c   = (state_q == IDLE) && req_c && legal_c;
  assign timeout_c = (state_q == BUSY) && !mem_ready_i &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the combinational core handshake.
  always_comb begin
    state_d      = state_q;
    core_stall_o = 1'b0;
    misaligned_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          if (legal_c) begin
            state_d      = BUSY;
            core_stall_o = 1'b1;
          end else begin
            misaligned_o = 1'b1;
          end
        end
      end
      BUSY: begin
        core_stall_o = 1'b1;
        if (mem_ready_i || timeout_c) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latched request, memory-side outputs, wait counter and captured read word.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_req_o  <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_be_o   <= 4'b0000;
      mem_addr_o <= 32'h0;
      mem_wd_o   <= 32'h0;
      bus_err_o  <= 1'b0;
      size_q     <= 3'b000;
      off_q      <= 2'b00;
      cnt_q      <= '0;
      data_q     <= 32'h0;
    end else begin
      mem_req_o <= (state_d == BUSY);
      bus_err_o <= timeout_c;
      if (start_c) begin
        mem_we_o   <= core_we_i;
        mem_be_o   <= be_c;
        mem_addr_o <= {core_addr_i[31:2], 2'b00};
        mem_wd_o   <= wd_c;
        size_q     <= core_size_i;
        off_q      <= core_addr_i[1:0];
        cnt_q      <= '0;
      end else if (state_q == BUSY) begin
        if (mem_ready_i)    data_q <= mem_rd_i;
        else if (timeout_c) data_q <= 32'h0;
        else                cnt_q  <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign byte_c = 8'(data_q >> {off_q, 3'b000});
  assign half_c = off_q[1] ? data_q[31:16] : data_q[15:0];

  // Lane extraction and extension; only presented during DONE.
  always_comb begin
    core_rd_o = 32'h0;
    if (state_q == DONE) begin
      case (size_q)
        SZ_B:    core_rd_o = {{24{byte_c[7]}}, byte_c};
        SZ_BU:   core_rd_o = {24'h0, byte_c};
        SZ_H:    core_rd_o = {{16{half_c[15]}}, half_c};
        SZ_HU:   core_rd_o = {16'h0, half_c};
        default: core_rd_o = data_q;
      endcase
    end
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load/store unit sitting directly downstream of the single-cycle RISC-V core's data-memory port, between the core and data memory.
- Converts byte/halfword/word requests (funct3-encoded size, byte address) into word-aligned memory transactions with byte enables.
- Returns sign- or zero-extended load data to the core.
- Stalls the core until memory acknowledges; flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waiting for mem_ready_i before aborting; range 1..255.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- core_req_i  in  1  core requests a data access this cycle.
- core_we_i  in  1  1 = store, 0 = load.
- core_size_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- core_addr_i  in  32  byte address (ALU result).
- core_wd_i  in  32  store data, LSB-justified.
- core_rd_o  out  32  extended load data; valid while core_stall_o=0 and core_req_i=1.
- core_stall_o  out  1  1 = hold PC/register write.
- misaligned_o  out  1  access rejected (alignment or illegal size).
- bus_err_o  out  1  timeout abort, one-cycle pulse.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_be_o  out  4  byte enables.
- mem_addr_o  out  32  word address, {core_addr_i[31:2],2'b00}.
- mem_wd_o  out  32  lane-replicated store data.
- mem_rd_i  in  32  memory read word.
- mem_ready_i  in  1  memory completes the request this cycle.

Behaviour:
- Reset (rst_i=0, async): state IDLE; all registered outputs 0; mem_req_o drops immediately, including mid-transaction; timeout counter cleared.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - core_req_i=1 and legal: latch addr/we/size/wd/be, go to BUSY.
  - Illegal access: stay IDLE, no memory access.
  - core_stall_o = core_req_i & legal.
- BUSY:
  - mem_req_o=1; mem_we_o, mem_be_o, mem_addr_o, mem_wd_o come from latched registers and stay stable until ready.
  - mem_ready_i=1: capture mem_rd_i into data register, go to DONE.
  - Otherwise increment the counter. When counter = TIMEOUT_CYCLES-1 with no ready, go to DONE, pulse bus_err_o next cycle, and set data register to 0.
  - core_stall_o=1.
- DONE:
  - mem_req_o=0; core_stall_o=0; core_rd_o valid; return to IDLE next cycle.
  - A new core_req_i seen in the following IDLE cycle starts a new transaction. The core has advanced PC, so this is a new instruction.
- Minimum latency: 3 cycles per access (IDLE, BUSY with ready, DONE). Each extra wait cycle adds 1.
- Byte enables:
  - B/BU: 4'b0001 << addr[1:0].
  - H/HU: 4'b0011 << addr[1:0].
  - W: 4'b1111.
  - Store data: B replicates wd[7:0] to all 4 lanes; H replicates wd[15:0] to both halves; W passes through.
- Load extraction from the captured word:
  - Byte: select lane addr[1:0].
  - Half: select half addr[1].
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- Legality:
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - Illegal size: codes 011, 110, 111; and 100/101 when we=1.
  - Misaligned or illegal: misaligned_o=1 combinationally while core_req_i=1 in IDLE, core_stall_o=0, core_rd_o=0, no mem_req_o.
- core_req_i deasserted while BUSY: the transaction still completes; the result is discarded.
- mem_ready_i in IDLE or DONE: ignored.
- core_rd_o while not DONE: 0.

Test Plan:
- LW addr 0x100, mem_rd_i=0xDEADBEEF, ready in 1st BUSY cycle -> mem_addr_o=0x100, be=1111, stall high 2 cycles, core_rd_o=0xDEADBEEF in DONE.
- LB addr 0x103 and LBU addr 0x103, mem word 0x80FF7F01 -> be=1000; LB returns 0xFFFFFF80; LBU returns 0x00000080.
- SH addr 0x202, wd=0x1234ABCD -> mem_we_o=1, be=1100, mem_wd_o=0xABCDABCD, mem_addr_o=0x200.
- LW addr 0x101 -> misaligned_o=1, stall=0, mem_req_o never asserted. SB with size 100 -> misaligned_o=1.
- TIMEOUT_CYCLES=4, mem_ready_i held 0 -> mem_req_o high for exactly 4 cycles, bus_err_o 1-cycle pulse, core_rd_o=0, stall released.
- Assert rst_i=0 mid-BUSY (async, between edges) -> mem_req_o and core_stall_o go to 0 immediately. After release, the next LW completes normally in 3 cycles.
